// File: rtl/pio32_evt_pkg.sv
// Shared constants for the pio32 input-event block: register map, debounce
// divider width, reset values and the Avalon byte-lane mask helper.
package pio32_evt_pkg;

   localparam logic [2:0] ADDR_LEVEL    = 3'd0;
   localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
   localparam logic [2:0] ADDR_FALL_EN  = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_IRQ_EN   = 3'd4;
   localparam logic [2:0] ADDR_DEB_DIV  = 3'd5;

   localparam int DEB_DIV_W = 16;

   localparam logic [31:0]          RST_REG     = 32'h0;
   localparam logic [DEB_DIV_W-1:0] RST_DEB_DIV = '0;

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
      return m;
   endfunction

endpackage

// File: rtl/pio32_evt_cond.sv
// Per-pin input conditioning: 2-flop synchronizer, then either a tick-driven
// debounce shift register (PIO32_EVT_DEBOUNCE_EN) or a plain level register.
module pio32_evt_cond
   import pio32_evt_pkg::*;
`ifdef PIO32_EVT_DEBOUNCE_EN
#(
   parameter int DEB_STAGES = 3
)
`endif
(
   input  logic csi_MCLK_clk,
   input  logic rsi_MRST_reset,
   input  logic pin_i,
`ifdef PIO32_EVT_DEBOUNCE_EN
   input  logic tick_i,
`endif
   output logic level_o
);

   logic sync1_q, sync2_q, level_q;

`ifdef PIO32_EVT_DEBOUNCE_EN
   logic [DEB_STAGES-1:0] sh_q;
   logic                  stable;

   // Accept a new level only once every stage agrees on it.
   assign stable = (&sh_q) | (~|sh_q);

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sh_q    <= '0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         if (tick_i) sh_q <= {sh_q[DEB_STAGES-2:0], sync2_q};
         if (stable && (sh_q[0] != level_q)) level_q <= sh_q[0];
      end
   end
`else
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         level_q <= sync2_q;
      end
   end
`endif

   assign level_o = level_q;

endmodule

// File: rtl/pio32_event_irq.sv
// GPIO input-event capture with W1C edge register and level IRQ on Avalon-MM.
// Debounce prescaler and DEB_DIV register exist only with PIO32_EVT_DEBOUNCE_EN.
module pio32_event_irq
   import pio32_evt_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEB_STAGES = 3
) (
   input  logic              csi_MCLK_clk,
   input  logic              rsi_MRST_reset,
   input  logic [2:0]        avs_evt_address,
   input  logic [31:0]       avs_evt_writedata,
   output logic [31:0]       avs_evt_readdata,
   input  logic [3:0]        avs_evt_byteenable,
   input  logic              avs_evt_write,
   input  logic              avs_evt_read,
   output logic              avs_evt_waitrequest,
   input  logic [WIDTH-1:0]  coe_pin_in,
   output logic              ins_irq_irq
);

   localparam logic [31:0] WMASK = (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1);

   logic [WIDTH-1:0] level;
   logic [31:0] lvl32, lvl_d_q, rise_en_q, fall_en_q, cap_q, cap_d, irq_en_q;
   logic [31:0] be_m, clr, set, rd_mux, rdata_q;
   logic        irq_q;

`ifdef PIO32_EVT_DEBOUNCE_EN
   logic [DEB_DIV_W-1:0] deb_div_q, pre_q, deb_wval;
   logic                 tick, deb_wr;

   assign tick     = (pre_q == deb_div_q);
   assign deb_wr   = avs_evt_write && (avs_evt_address == ADDR_DEB_DIV);
   assign deb_wval = (avs_evt_writedata[DEB_DIV_W-1:0] & be_m[DEB_DIV_W-1:0])
                   | (deb_div_q & ~be_m[DEB_DIV_W-1:0]);

   // Writing the divider restarts the prescaler so the new period starts cleanly.
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         deb_div_q <= RST_DEB_DIV;
         pre_q     <= '0;
      end else if (deb_wr) begin
         deb_div_q <= deb_wval;
         pre_q     <= '0;
      end else begin
         pre_q <= tick ? '0 : pre_q + DEB_DIV_W'(1);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio32_evt_cond #(.DEB_STAGES(DEB_STAGES)) u_cond (
         .csi_MCLK_clk   (csi_MCLK_clk),
         .rsi_MRST_reset (rsi_MRST_reset),
         .pin_i          (coe_pin_in[i]),
         .tick_i         (tick),
         .level_o        (level[i])
      );
   end
`else
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio32_evt_cond u_cond (
         .csi_MCLK_clk   (csi_MCLK_clk),
         .rsi_MRST_reset (rsi_MRST_reset),
         .pin_i          (coe_pin_in[i]),
         .level_o        (level[i])
      );
   end
`endif

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [31:0] m);
      return ((wd & m) | (old & ~m)) & WMASK;
   endfunction

   always_comb begin
      lvl32              = '0;
      lvl32[WIDTH-1:0]   = level;
      be_m               = be_mask(avs_evt_byteenable);
      set = ((lvl32 & ~lvl_d_q) & rise_en_q) | ((~lvl32 & lvl_d_q) & fall_en_q);
      clr = (avs_evt_write && avs_evt_address == ADDR_EDGE_CAP) ? (avs_evt_writedata & be_m) : '0;
      // A new edge in the clearing cycle must not be lost.
      cap_d = ((cap_q & ~clr) | set) & WMASK;
   end

   always_comb begin
      rd_mux = '0;
      case (avs_evt_address)
         ADDR_LEVEL:    rd_mux = lvl32;
         ADDR_RISE_EN:  rd_mux = rise_en_q;
         ADDR_FALL_EN:  rd_mux = fall_en_q;
         ADDR_EDGE_CAP: rd_mux = cap_q;
         ADDR_IRQ_EN:   rd_mux = irq_en_q;
`ifdef PIO32_EVT_DEBOUNCE_EN
         ADDR_DEB_DIV:  rd_mux = 32'(deb_div_q);
`endif
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         lvl_d_q   <= RST_REG;
         rise_en_q <= RST_REG;
         fall_en_q <= RST_REG;
         cap_q     <= RST_REG;
         irq_en_q  <= RST_REG;
         rdata_q   <= RST_REG;
         irq_q     <= 1'b0;
      end else begin
         lvl_d_q <= lvl32;
         cap_q   <= cap_d;
         irq_q   <= |(cap_q & irq_en_q);
         if (avs_evt_read) rdata_q <= rd_mux;
         if (avs_evt_write) begin
            case (avs_evt_address)
               ADDR_RISE_EN: rise_en_q <= merge(rise_en_q, avs_evt_writedata, be_m);
               ADDR_FALL_EN: fall_en_q <= merge(fall_en_q, avs_evt_writedata, be_m);
               ADDR_IRQ_EN:  irq_en_q  <= merge(irq_en_q,  avs_evt_writedata, be_m);
               default: ;
            endcase
         end
      end
   end

   assign avs_evt_readdata    = rdata_q;
   assign avs_evt_waitrequest = 1'b0;
   assign ins_irq_irq         = irq_q;

endmodule
